// File: rtl/div_iter_if.sv
// EX-side request/response bundle for the iterative divider.
// The master (EX) drives operands and start/annul; the slave (divider) returns result/ready.
interface div_iter_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU); one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor short-cuts through BYZERO to a zero result.
module div_iter (
    input  logic      clk,
    input  logic      resetn,
    div_iter_if.slave bus
);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
`else
    typedef enum logic [1:0] {IDLE, ON, END} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        sign1, sign2;
    logic [32:0] trial;
    logic        qbit;
    logic [31:0] quot_fix, rem_fix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        ready_d  = ready_q;
        sign1    = bus.signed_div_i & bus.opdata1_i[31];
        sign2    = bus.signed_div_i & bus.opdata2_i[31];
        // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
        trial    = {rem_q[31:0], dvd_q[31]};
        qbit     = 1'b0;
        quot_fix = '0;
        rem_fix  = '0;

        case (state_q)
            IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    dvd_d   = sign1 ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
                    dvs_d   = sign2 ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
                    q_neg_d = sign1 ^ sign2;
                    r_neg_d = sign1;
                    rem_d   = '0;
                    cnt_d   = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opdata2_i == 32'd0) state_d = BYZERO;
                    else                        state_d = ON;
`else
                    state_d = ON;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            BYZERO: begin
                if (bus.annul_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
`endif
            ON: begin
                if (bus.annul_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (trial >= {1'b0, dvs_q}) begin
                        rem_d = trial - {1'b0, dvs_q};
                        qbit  = 1'b1;
                    end else begin
                        rem_d = trial;
                    end
                    dvd_d = {dvd_q[30:0], qbit};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        quot_fix = q_neg_q ? (~dvd_d + 32'd1) : dvd_d;
                        rem_fix  = r_neg_q ? (~rem_d[31:0] + 32'd1) : rem_d[31:0];
                        result_d = {rem_fix, quot_fix};
                        ready_d  = 1'b1;
                        state_d  = END;
                    end
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: fixed 33-cycle latency, sign rules, zero divisor, annul, async reset.
module tb_div_iter;
    logic clk;
    logic resetn;
    int unsigned tests;
    int unsigned errors;

    div_iter_if dif ();

    div_iter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start in cycle 0, scramble the operand inputs afterwards, check exact latency, then drop start.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [63:0] exp);
        @(posedge clk); #1;
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        @(posedge clk); #1;
        dif.opdata1_i    = ~a;
        dif.opdata2_i    = 32'h0000_0003;
        dif.signed_div_i = ~sgn;
        repeat (lat - 2) @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_early"}, {63'b0, dif.ready_o}, 64'd0);
        @(negedge clk);
        check_eq({tag, "_ready"}, {63'b0, dif.ready_o}, 64'd1);
        check_eq({tag, "_result"}, dif.result_o, exp);
        dif.start_i = 1'b0;
        @(negedge clk);
        check_eq({tag, "_clr_rdy"}, {63'b0, dif.ready_o}, 64'd0);
        check_eq({tag, "_clr_res"}, dif.result_o, 64'd0);
    endtask

    initial begin
        logic seen_ready;
        tests  = 0;
        errors = 0;
        resetn = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        #3;
        check_eq("rst_ready", {63'b0, dif.ready_o}, 64'd0);
        check_eq("rst_result", dif.result_o, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_div("u100_7",    1'b0, 32'd100,       32'd7,         33, 64'h00000002_0000000E);
        run_div("s_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         33, 64'hFFFFFFFF_FFFFFFFD);
        run_div("u_m7_2",    1'b0, 32'hFFFFFFF9,  32'd2,         33, 64'h00000001_7FFFFFFC);
        run_div("s_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  33, 64'h00000001_FFFFFFFD);
        run_div("s_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  33, 64'h00000000_80000000);
        run_div("u_max_16",  1'b0, 32'hFFFFFFFF,  32'h10,        33, 64'h0000000F_0FFFFFFF);
`ifdef DIV_ZERO_FAST_EN
        run_div("u5_0",      1'b0, 32'd5,         32'd0,         2,  64'h0);
`else
        run_div("u5_0",      1'b0, 32'd5,         32'd0,         33, 64'h00000005_FFFFFFFF);
`endif

        // start and annul together in IDLE: annul wins, nothing starts
        @(posedge clk); #1;
        dif.opdata1_i = 32'd50; dif.opdata2_i = 32'd5; dif.signed_div_i = 1'b0;
        dif.start_i = 1'b1; dif.annul_i = 1'b1;
        @(posedge clk); #1;
        dif.start_i = 1'b0; dif.annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ready_o) seen_ready = 1'b1;
        end
        check_eq("idle_annul", {63'b0, seen_ready}, 64'd0);

        // annul in cycle 10 of 1000/3
        @(posedge clk); #1;
        dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3; dif.start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        dif.annul_i = 1'b1; dif.start_i = 1'b0;
        @(posedge clk); #1;
        dif.annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ready_o) seen_ready = 1'b1;
        end
        check_eq("annul_no_ready", {63'b0, seen_ready}, 64'd0);
        check_eq("annul_result", dif.result_o, 64'd0);
        run_div("u9_4_after_annul", 1'b0, 32'd9, 32'd4, 33, 64'h00000001_00000002);

        // hold start through END: ready and result held, annul ignored, then async reset clears
        @(posedge clk); #1;
        dif.opdata1_i = 32'd100; dif.opdata2_i = 32'd7; dif.signed_div_i = 1'b0; dif.start_i = 1'b1;
        repeat (33) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dif.annul_i = 1'b0;
        check_eq("end_hold_ready", {63'b0, dif.ready_o}, 64'd1);
        check_eq("end_hold_result", dif.result_o, 64'h00000002_0000000E);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_ready", {63'b0, dif.ready_o}, 64'd0);
        check_eq("async_rst_result", dif.result_o, 64'd0);
        dif.start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // reset in cycle 20 of a division, then normal restart
        @(posedge clk); #1;
        dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3; dif.start_i = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        resetn = 1'b0;
        dif.start_i = 1'b0;
        #1;
        check_eq("mid_rst_ready", {63'b0, dif.ready_o}, 64'd0);
        check_eq("mid_rst_result", dif.result_o, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_div("u1000_3_after_rst", 1'b0, 32'd1000, 32'd3, 33, 64'h00000001_0000014D);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider for the EX stage. It serves DIV and DIVU and answers the EX-side `start_i`/`ready_o` handshake. It latches its operands once, runs one quotient bit per cycle, and returns `{remainder, quotient}` as a 64-bit registered result for the HI/LO write path. EX holds its stall request while the divider is busy.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- `clk`  in  1  — the only clock.
- `resetn`  in  1  — reset, asynchronous and active-low.
- `signed_div_i`  in  1  — 1 selects signed (DIV); 0 selects unsigned (DIVU).
- `opdata1_i`  in  32  — dividend.
- `opdata2_i`  in  32  — divisor.
- `start_i`  in  1  — request. EX holds it high until it sees `ready_o`.
- `annul_i`  in  1  — aborts a division in progress.
- `result_o`  out  64  — `{remainder[63:32], quotient[31:0]}`, registered.
- `ready_o`  out  1  — result valid, registered.

## Operation
- State machine states:
  - IDLE.
  - BYZERO, present only with the macro below.
  - ON.
  - END.
- Reset (`resetn`=0, asynchronous):
  - state goes to IDLE;
  - `ready_o`=0;
  - `result_o`=0;
  - the iteration counter goes to 0.
- IDLE:
  - with `start_i`=1 and `annul_i`=0, latch the operands;
  - with the macro and `opdata2_i`==0, go to BYZERO;
  - otherwise go to ON with cnt=0.
  - Operands are sampled only at this transition; later changes on the inputs are ignored.
- Signed preprocessing, done at latch time:
  - the dividend and divisor are replaced by their magnitudes (two's-complement negate when bit 31 is set and `signed_div_i`=1);
  - record `q_neg` = sign1 XOR sign2;
  - record `r_neg` = sign1.
- ON, one restoring step per cycle:
  - shift the 33-bit partial remainder left, bringing in the next dividend bit MSB-first;
  - if the partial remainder ≥ the divisor, subtract and shift in quotient bit 1; otherwise shift in 0;
  - cnt increments each step;
  - after the step at cnt=31, go to END;
  - while in ON, `ready_o`=0.
- Result on the ON→END transition:
  - quotient is negated if `q_neg`; remainder is negated if `r_neg`;
  - the result is loaded into `result_o` and `ready_o` is set to 1.
- END:
  - while `start_i`=1, hold state, `result_o` and `ready_o`=1;
  - when `start_i`=0, go to IDLE and clear `ready_o` and `result_o` to 0 on the same edge.
  - A new division always passes through IDLE first; there is no back-to-back restart from END.
- `annul_i`=1 in ON or BYZERO: go to IDLE on the next edge, `ready_o` stays 0, `result_o`=0. `annul_i` is ignored in END.
- Arithmetic rules:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0, with no trap.

## Timing
- Call the cycle in which IDLE sees `start_i`=1 cycle 0.
- Normal path:
  - ON occupies cycles 1–32;
  - `ready_o`=1 from cycle 33;
  - fixed latency of 33 cycles, independent of the operand values.
- BYZERO path (macro only):
  - BYZERO in cycle 1;
  - END with `ready_o`=1 in cycle 2.
- EX protocol: EX drops `start_i` in the cycle it observes `ready_o`=1. `ready_o` is therefore a one-cycle pulse, and the divider is back in IDLE the following cycle.
- `start_i` and `annul_i` both high in IDLE: `annul_i` wins and the state stays IDLE.
- `resetn` asserted mid-operation: all outputs clear immediately, without waiting for a clock edge.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - a divisor of 0 takes the BYZERO path;
  - `result_o` = 64'h0 with `ready_o` in cycle 2.
- `DIV_ZERO_FAST_EN` undefined:
  - there is no BYZERO state, and a divisor of 0 runs the full 32 steps;
  - the result is the natural restoring output on the magnitudes, quotient 0xFFFFFFFF and remainder = |dividend|, followed by the normal sign fix-up;
  - latency is 33 cycles.

## Test plan
- Unsigned 100 / 7 (`signed_div_i`=0), start in cycle 0 → cycle 33: `ready_o`=1, `result_o`=64'h00000002_0000000E. Drop start → cycle 34: `ready_o`=0, `result_o`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, at cycle 33.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0x00000000. Unsigned 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- Unsigned 5 / 0:
  - with `DIV_ZERO_FAST_EN`: `ready_o` in cycle 2, `result_o`=0;
  - without it: `ready_o` in cycle 33, quotient 0xFFFFFFFF, remainder 5.
- Start 1000 / 3, pulse `annul_i` in cycle 10 → cycle 11 IDLE, `ready_o` never rises. Restart with 9 / 4 → quotient 2, remainder 1, exactly 33 cycles after the new start.
- Assert `resetn`=0 in cycle 20 of a division → `ready_o`=0 and `result_o`=0 asynchronously. After release, IDLE accepts a new start normally.
